cdma_csb_reg_initiator: RTL and testbench
=========================================

// Module: cdma_csb_reg_initiator
// PURPOSE
// CSB-side initiator for the CDMA single register file. Accepts CSB request packets, decodes page and
// offset, drives the flat register port (reg_offset / reg_wr_en / reg_wr_data), and captures reg_rd_data.
// Returns read data and non-posted write acks on a valid-only response channel.
// Sits between the CSB tree and the CDMA register slave.
// PARAMETERS
// BASE_PAGE  12'h005  byte_addr[23:12] value that selects this block (0x5000 page)
// REG_SPAN   12'h010  byte offsets >= REG_SPAN are out of window (error, no side effect)
// PORTS
// nvdla_core_clk  in   1   core clock; all logic rising-edge
// nvdla_core_rst  in   1   synchronous active-high reset
// req_pvld        in   1   CSB request valid
// req_prdy        out  1   CSB request ready
// req_pd          in   63  [21:0] word addr, [53:22] wdat, [54] write, [55] nposted, [62:56] unused
// rsp_valid       out  1   response valid, single-cycle pulse, no backpressure
// rsp_pd          out  34  [31:0] rdat (0 for write ack), [32] error, [33] type (0=read, 1=write ack)
// reg_offset      out  12  register byte offset to slave
// reg_wr_en       out  1   register write strobe, one cycle
// reg_wr_data     out  32  register write data
// reg_rd_data     in   32  combinational read data from slave for the current reg_offset
// BEHAVIOUR
// - Reset values: req_prdy=1 (state IDLE), rsp_valid=0, rsp_pd=0, reg_offset=0, reg_wr_en=0, reg_wr_data=0.
// - Reset mid-operation: return to IDLE, drop any in-flight access or response, issue no strobe.
// - byte_addr[23:0] = {req_pd[21:0], 2'b00}.
//   sel = (byte_addr[23:12] == BASE_PAGE).
//   oob = (byte_addr[11:0] >= REG_SPAN).
// - FSM states: IDLE, ACCESS, RESP. req_prdy = (state == IDLE).
//   - IDLE, req_pvld=1, sel=1: register offset, wdat, write, nposted and oob; go to ACCESS.
//   - IDLE, req_pvld=1, sel=0: accept and silently drop; stay IDLE, no response.
//   - ACCESS, one cycle: reg_offset/reg_wr_data held from capture.
//     - reg_wr_en = write & ~oob.
//     - Read: latch (oob ? 0 : reg_rd_data) at the end of the cycle.
//     - Next state: RESP if (read | nposted), else IDLE.
//   - RESP, one cycle: rsp_valid=1 with rsp_pd = {type, oob, data}; then IDLE.
// - Latency: handshake at edge T.
//   - reg_wr_en is high in cycle T+1.
//   - rsp_valid is high in cycle T+2.
//   - Max throughput is one request per 3 cycles (2 for a posted write).
// - Posted write: no response even when oob=1 (error is silently lost).
// - Non-posted write: ack with rsp_pd[33]=1, [32]=oob, [31:0]=0.
// - Read: rsp_pd[33]=0, [32]=oob, [31:0] = latched data.
// - reg_offset and reg_wr_data keep their last value outside ACCESS.
// - reg_wr_en is 0 outside ACCESS.
// - req_pd[62:56] is ignored. The req_pd value is sampled only on the handshake cycle.
// STRUCTURE
// - Shared package: req_pd/rsp_pd field bit positions, rsp type codes, FSM state encoding (2-bit).
// - No sub-module: decode, FSM and capture registers stay inline (about 150 lines).
// TESTING
// - Read 0x5008 (req addr 22'h1402, write=0), slave returns 32'h0003000F
//   -> rsp_valid in cycle T+2, rsp_pd = {1'b0, 1'b0, 32'h0003000F}.
// - Posted write 0x5004, wdat=1
//   -> reg_wr_en=1 for exactly cycle T+1 with reg_offset=12'h004, reg_wr_data=1.
//   -> no rsp_valid. req_prdy is back to 1 in cycle T+2.
// - Non-posted write 0x5008, wdat=32'h00020005
//   -> single reg_wr_en in T+1; rsp_pd = {1'b1, 1'b0, 32'h0} in T+2.
// - Out-of-window read 0x5040 -> no reg_wr_en; rsp_pd = {1'b0, 1'b1, 32'h0}.
// - Out-of-window non-posted write 0x5040 -> no reg_wr_en; rsp_pd = {1'b1, 1'b1, 32'h0}.
// - Other-page request (addr 22'h0400, i.e. byte 0x1000)
//   -> accepted with req_prdy=1, no strobe, no response.
// - Back-to-back req_pvld held high:
//   -> req_prdy drops in ACCESS and RESP; the second request is accepted in the first IDLE cycle.
// - Reset asserted during ACCESS of a non-posted write
//   -> reg_wr_en=0 from the next cycle, no rsp_valid, all outputs at reset values.

Source files
------------

// File: rtl/cdma_csb_reg_initiator_pkg.sv
// rtl/cdma_csb_reg_initiator_pkg.sv - CSB request/response field layout and FSM encoding
package cdma_csb_reg_initiator_pkg;

  localparam int REQ_PD_W        = 63;
  localparam int RSP_PD_W        = 34;
  localparam int REQ_ADDR_LSB    = 0;
  localparam int REQ_ADDR_W      = 22;
  localparam int REQ_WDAT_LSB    = 22;
  localparam int REQ_WRITE_BIT   = 54;
  localparam int REQ_NPOSTED_BIT = 55;
  localparam int RSP_ERR_BIT     = 32;
  localparam int RSP_TYPE_BIT    = 33;

  localparam logic RSP_TYPE_READ  = 1'b0;
  localparam logic RSP_TYPE_WRACK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/cdma_csb_reg_initiator.sv
// rtl/cdma_csb_reg_initiator.sv - CSB request decoder driving the flat CDMA register port
module cdma_csb_reg_initiator
  import cdma_csb_reg_initiator_pkg::*;
#(
  parameter logic [11:0] BASE_PAGE = 12'h005,
  parameter logic [11:0] REG_SPAN  = 12'h010
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                req_pvld,
  output logic                req_prdy,
  input  logic [REQ_PD_W-1:0] req_pd,
  output logic                rsp_valid,
  output logic [RSP_PD_W-1:0] rsp_pd,
  output logic [11:0]         reg_offset,
  output logic                reg_wr_en,
  output logic [31:0]         reg_wr_data,
  input  logic [31:0]         reg_rd_data
);

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_offset;
  logic [31:0] r_wdat;
  logic [31:0] r_rdat;
  logic        r_write;
  logic        r_nposted;
  logic        r_oob;

  logic [23:0] w_byte_addr;
  logic        w_sel;
  logic        w_oob;
  logic        w_accept;
  logic        w_unused_req;

  assign w_byte_addr  = {req_pd[REQ_ADDR_LSB +: REQ_ADDR_W], 2'b00};
  assign w_sel        = (w_byte_addr[23:12] == BASE_PAGE);
  assign w_oob        = (w_byte_addr[11:0] >= REG_SPAN);
  assign w_unused_req = ^req_pd[REQ_PD_W-1:REQ_NPOSTED_BIT+1];

  always_comb begin
    w_next      = r_state;
    req_prdy    = 1'b0;
    w_accept    = 1'b0;
    reg_wr_en   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_pd      = '0;
    case (r_state)
      ST_IDLE: begin
        req_prdy = 1'b1;
        w_accept = req_pvld;
        // Other-page requests are consumed here with no response.
        if (req_pvld && w_sel) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        reg_wr_en = r_write & ~r_oob;
        w_next    = (!r_write || r_nposted) ? ST_RESP : ST_IDLE;
      end
      ST_RESP: begin
        rsp_valid                 = 1'b1;
        rsp_pd[31:0]              = r_rdat;
        rsp_pd[RSP_ERR_BIT]       = r_oob;
        rsp_pd[RSP_TYPE_BIT]      = r_write ? RSP_TYPE_WRACK : RSP_TYPE_READ;
        w_next                    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state   <= ST_IDLE;
      r_offset  <= '0;
      r_wdat    <= '0;
      r_rdat    <= '0;
      r_write   <= 1'b0;
      r_nposted <= 1'b0;
      r_oob     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && w_sel) begin
        r_offset  <= w_byte_addr[11:0];
        r_wdat    <= req_pd[REQ_WDAT_LSB +: 32];
        r_write   <= req_pd[REQ_WRITE_BIT];
        r_nposted <= req_pd[REQ_NPOSTED_BIT];
        r_oob     <= w_oob;
      end
      // Write acks and out-of-window reads return zero data.
      if (r_state == ST_ACCESS) begin
        r_rdat <= (r_write || r_oob) ? 32'h0 : reg_rd_data;
      end
    end
  end

  assign reg_offset  = r_offset;
  assign reg_wr_data = r_wdat;

endmodule

// File: tb/tb_cdma_csb_reg_initiator.sv
// tb/tb_cdma_csb_reg_initiator.sv - directed vector bench for the CSB register initiator
module tb_cdma_csb_reg_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_pvld;
  logic        req_prdy;
  logic [62:0] req_pd;
  logic        rsp_valid;
  logic [33:0] rsp_pd;
  logic [11:0] reg_offset;
  logic        reg_wr_en;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdma_csb_reg_initiator dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .req_pvld       (req_pvld),
    .req_prdy       (req_prdy),
    .req_pd         (req_pd),
    .rsp_valid      (rsp_valid),
    .rsp_pd         (rsp_pd),
    .reg_offset     (reg_offset),
    .reg_wr_en      (reg_wr_en),
    .reg_wr_data    (reg_wr_data),
    .reg_rd_data    (reg_rd_data)
  );

  typedef struct {
    logic        wr;
    logic        np;
    logic [21:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [6:0]  junk;
    logic        exp_sel;
    logic        exp_wr_en;
    logic [11:0] exp_off;
    logic        exp_rsp;
    logic [33:0] exp_pd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [62:0] mk_pd(input logic [6:0] junk, input logic np, input logic wr,
                                        input logic [31:0] wdat, input logic [21:0] addr);
    return {junk, np, wr, wdat, addr};
  endfunction

  task automatic drive(input logic wr, input logic np, input logic [21:0] addr, input logic [31:0] wdat);
    req_pvld = 1'b1;
    req_pd   = mk_pd(7'h00, np, wr, wdat, addr);
  endtask

  initial begin
    //          wr    np    addr      wdat          rdat          junk   sel   wren  off     rsp   pd
    vecs[0] = '{1'b0, 1'b0, 22'h1402, 32'h0,        32'h0003000F, 7'h00, 1'b1, 1'b0, 12'h008, 1'b1, 34'h0_0003_000F};
    vecs[1] = '{1'b1, 1'b0, 22'h1401, 32'h1,        32'h0,        7'h00, 1'b1, 1'b1, 12'h004, 1'b0, 34'h0};
    vecs[2] = '{1'b1, 1'b1, 22'h1402, 32'h00020005, 32'h0,        7'h00, 1'b1, 1'b1, 12'h008, 1'b1, 34'h2_0000_0000};
    vecs[3] = '{1'b0, 1'b0, 22'h1410, 32'h0,        32'hDEADBEEF, 7'h00, 1'b1, 1'b0, 12'h040, 1'b1, 34'h1_0000_0000};
    vecs[4] = '{1'b1, 1'b1, 22'h1410, 32'h0000FFFF, 32'h0,        7'h00, 1'b1, 1'b0, 12'h040, 1'b1, 34'h3_0000_0000};
    vecs[5] = '{1'b0, 1'b1, 22'h0400, 32'h0,        32'h11111111, 7'h00, 1'b0, 1'b0, 12'h000, 1'b0, 34'h0};
    vecs[6] = '{1'b0, 1'b0, 22'h1403, 32'h0,        32'h12345678, 7'h00, 1'b1, 1'b0, 12'h00C, 1'b1, 34'h0_1234_5678};
    vecs[7] = '{1'b1, 1'b0, 22'h1404, 32'hCAFE0000, 32'h0,        7'h00, 1'b1, 1'b0, 12'h010, 1'b0, 34'h0};
    vecs[8] = '{1'b1, 1'b1, 22'h1400, 32'hA5A5A5A5, 32'h0,        7'h7F, 1'b1, 1'b1, 12'h000, 1'b1, 34'h2_0000_0000};
    vecs[9] = '{1'b1, 1'b1, 22'h5402, 32'h00000042, 32'h0,        7'h00, 1'b0, 1'b0, 12'h000, 1'b0, 34'h0};

    rst         = 1'b1;
    req_pvld    = 1'b0;
    req_pd      = '0;
    reg_rd_data = '0;
    repeat (3) @(negedge clk);

    chk("rst_prdy",   {63'b0, req_prdy},    64'd1);
    chk("rst_rspv",   {63'b0, rsp_valid},   64'd0);
    chk("rst_rsppd",  {30'b0, rsp_pd},      64'd0);
    chk("rst_off",    {52'b0, reg_offset},  64'd0);
    chk("rst_wren",   {63'b0, reg_wr_en},   64'd0);
    chk("rst_wdata",  {32'b0, reg_wr_data}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_pvld    = 1'b1;
      req_pd      = mk_pd(vecs[i].junk, vecs[i].np, vecs[i].wr, vecs[i].wdat, vecs[i].addr);
      reg_rd_data = vecs[i].rdat;
      @(negedge clk);
      req_pvld = 1'b0;
      req_pd   = '1;
      chk($sformatf("v%0d_t1_prdy", i), {63'b0, req_prdy}, {63'b0, !vecs[i].exp_sel});
      chk($sformatf("v%0d_t1_wren", i), {63'b0, reg_wr_en}, {63'b0, vecs[i].exp_wr_en});
      if (vecs[i].exp_sel)
        chk($sformatf("v%0d_t1_off", i), {52'b0, reg_offset}, {52'b0, vecs[i].exp_off});
      if (vecs[i].exp_wr_en)
        chk($sformatf("v%0d_t1_wdata", i), {32'b0, reg_wr_data}, {32'b0, vecs[i].wdat});
      @(negedge clk);
      chk($sformatf("v%0d_t2_wren", i), {63'b0, reg_wr_en}, 64'd0);
      chk($sformatf("v%0d_t2_rspv", i), {63'b0, rsp_valid}, {63'b0, vecs[i].exp_rsp});
      chk($sformatf("v%0d_t2_prdy", i), {63'b0, req_prdy}, {63'b0, !vecs[i].exp_rsp});
      if (vecs[i].exp_rsp)
        chk($sformatf("v%0d_t2_rsppd", i), {30'b0, rsp_pd}, {30'b0, vecs[i].exp_pd});
      @(negedge clk);
      chk($sformatf("v%0d_t3_rspv", i), {63'b0, rsp_valid}, 64'd0);
      chk($sformatf("v%0d_t3_prdy", i), {63'b0, req_prdy}, 64'd1);
    end

    // Back-to-back: read 0x5004 then non-posted write 0x500C with req_pvld held high.
    @(negedge clk);
    reg_rd_data = 32'h000000AB;
    drive(1'b0, 1'b0, 22'h1401, 32'h0);
    @(negedge clk);
    chk("b2b_t1_prdy", {63'b0, req_prdy}, 64'd0);
    drive(1'b1, 1'b1, 22'h1403, 32'h00000077);
    @(negedge clk);
    chk("b2b_t2_prdy", {63'b0, req_prdy}, 64'd0);
    chk("b2b_t2_rsppd", {30'b0, rsp_pd}, {30'b0, 34'h0_0000_00AB});
    @(negedge clk);
    chk("b2b_t3_prdy", {63'b0, req_prdy}, 64'd1);
    @(negedge clk);
    req_pvld = 1'b0;
    chk("b2b_t4_wren", {63'b0, reg_wr_en}, 64'd1);
    chk("b2b_t4_off", {52'b0, reg_offset}, {52'b0, 12'h00C});
    chk("b2b_t4_wdata", {32'b0, reg_wr_data}, 64'h77);
    @(negedge clk);
    chk("b2b_t5_rspv", {63'b0, rsp_valid}, 64'd1);
    chk("b2b_t5_rsppd", {30'b0, rsp_pd}, {30'b0, 34'h2_0000_0000});
    @(negedge clk);

    // Reset during ACCESS of a non-posted write.
    drive(1'b1, 1'b1, 22'h1402, 32'h0BADF00D);
    @(negedge clk);
    req_pvld = 1'b0;
    chk("rstmid_t1_wren", {63'b0, reg_wr_en}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_wren",  {63'b0, reg_wr_en},   64'd0);
    chk("rstmid_rspv",  {63'b0, rsp_valid},   64'd0);
    chk("rstmid_prdy",  {63'b0, req_prdy},    64'd1);
    chk("rstmid_rsppd", {30'b0, rsp_pd},      64'd0);
    chk("rstmid_off",   {52'b0, reg_offset},  64'd0);
    chk("rstmid_wdata", {32'b0, reg_wr_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_after_rspv", {63'b0, rsp_valid}, 64'd0);
    chk("rstmid_after_wren", {63'b0, reg_wr_en}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
